// File: rtl/jtag_loader_pkg.sv
// Shared JTAG loader definitions: IR codes, word geometry, write record type.
// Combinational helpers only; no latency or flow control lives here.
package jtag_loader_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [3:0] IR_CTRL = 4'h8;
  localparam logic [3:0] IR_ADDR = 4'h9;
  localparam logic [3:0] IR_DATA = 4'hA;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } loader_write_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, show-ahead head on dout, 1-cycle write-to-empty-deassert.
// Push is taken when not full or when popping the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer counts wraps, so equal indices split into full vs empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_mem_writer.sv
// Buffers loader write strobes and replays them as req/ack memory writes, min 2 cycles each.
// Memory stalls via mem_ack; a full buffer drops new strobes and raises sticky overflow.
module jtag_mem_writer
  import jtag_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loader_we,
  input  logic [ADDR_WIDTH-1:0] loader_addr,
  input  logic [DATA_WIDTH-1:0] loader_data,
  input  logic                  loader_reset,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  overflow,
  output logic                  misaligned,
  output logic [31:0]           words_written
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  wr_state_t   state;
  logic        aligned;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [EW-1:0] head;

  assign aligned = word_aligned(loader_addr[1:0]);
  assign pop     = (state == ST_REQ) & mem_ack;
  assign busy    = ~fifo_empty | (state == ST_REQ);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (loader_we & aligned),
    .din   ({loader_addr, loader_data}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_write_en  <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      overflow      <= 1'b0;
      misaligned    <= 1'b0;
      words_written <= '0;
      core_reset    <= 1'b1;
    end else begin
      // Core stays held until the last buffered write has been acked.
      core_reset <= loader_reset | busy;

      if (loader_we && !aligned) begin
        misaligned <= 1'b1;
      end else if (loader_we && fifo_full && !pop) begin
        overflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_addr     <= head[EW-1:DATA_WIDTH];
            mem_data     <= head[DATA_WIDTH-1:0];
            mem_write_en <= 1'b1;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_write_en  <= 1'b0;
            words_written <= words_written + 32'd1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_mem_writer.sv
// Randomised and directed bench for jtag_mem_writer against a transaction-level queue model.
module tb_jtag_mem_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        loader_we = 1'b0;
  logic [31:0] loader_addr = '0;
  logic [31:0] loader_data = '0;
  logic        loader_reset = 1'b0;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack = 1'b0;
  logic        core_reset;
  logic        busy;
  logic        overflow;
  logic        misaligned;
  logic [31:0] words_written;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  // Model: pending writes (head is the one on the bus when m_act), plus outputs.
  wr_t         mq[$];
  bit          m_act;
  int unsigned m_cnt;
  bit          m_ovf;
  bit          m_mis;
  bit          m_crst;

  wr_t obs[$];
  wr_t exp_q[$];

  jtag_mem_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .loader_we     (loader_we),
    .loader_addr   (loader_addr),
    .loader_data   (loader_data),
    .loader_reset  (loader_reset),
    .mem_write_en  (mem_write_en),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_ack       (mem_ack),
    .core_reset    (core_reset),
    .busy          (busy),
    .overflow      (overflow),
    .misaligned    (misaligned),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Record every accepted write seen on the memory port.
  always @(negedge clk) begin
    if (!reset && mem_write_en && mem_ack) obs.push_back({mem_addr, mem_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit ack, input bit lrst);
    bit busy_m;
    bit pop_m;
    bit push_m;
    reset        = rst;
    loader_we    = we;
    loader_addr  = a;
    loader_data  = d;
    mem_ack      = ack;
    loader_reset = lrst;
    if (rst) begin
      mq.delete();
      m_act  = 0;
      m_cnt  = 0;
      m_ovf  = 0;
      m_mis  = 0;
      m_crst = 1;
    end else begin
      busy_m = (mq.size() != 0) || m_act;
      m_crst = lrst | busy_m;
      pop_m  = m_act && ack;
      push_m = 0;
      if (we) begin
        if (a[1:0] != 2'b00) m_mis = 1;
        else if (mq.size() < DEPTH || pop_m) push_m = 1;
        else m_ovf = 1;
      end
      if (pop_m) begin
        void'(mq.pop_front());
        m_act = 0;
        m_cnt++;
      end else if (!m_act && mq.size() != 0) begin
        m_act = 1;
      end
      if (push_m) mq.push_back({a, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, ack, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(1, 1, 32'h40, 32'h1, 1, 1);
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_write_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data); end
    checks++; if (overflow !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b mis=%b want 0/0", overflow, misaligned); end
    checks++; if (words_written !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", words_written); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core: got %b want 1", core_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    step(1, 0, 32'h0, 32'h0, 0, 0);
    obs.delete();
    step(0, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    checks++; if (mem_write_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_queued: got we=%b busy=%b want 0/1", mem_write_en, busy); end
    step(0, 0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_write_en !== 1'b1 || mem_addr !== 32'h100 || mem_data !== 32'hDEADBEEF || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold%0d: got we=%b addr=%h data=%h busy=%b want 1/100/deadbeef/1", i, mem_write_en, mem_addr, mem_data, busy);
      end
      step(0, 0, 32'h0, 32'h0, i == 2, 0);
    end
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b want 0", mem_write_en); end
    checks++; if (words_written !== 32'd1) begin errors++; $display("FAIL single_count: got %0d want 1", words_written); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    checks++; if (obs.size() != 1 || obs[0] !== {32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL single_obs: got %0d writes want 1 of 100/deadbeef", obs.size()); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    step(1, 0, 32'h0, 32'h0, 0, 0);
    obs.delete();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      d = $urandom;
      if (i < 8) exp_q.push_back({32'h200 + 32'(4 * i), d});
      step(0, 1, 32'h200 + 32'(4 * i), d, 0, 0);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL ovf_head: got we=%b addr=%h want 1/200", mem_write_en, mem_addr); end
    for (int c = 0; c < 40 && obs.size() < 8; c++) idle(1, 1);
    idle(4, 1);
    checks++; if (obs.size() != 8) begin errors++; $display("FAIL ovf_drain_count: got %0d want 8", obs.size()); end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (words_written !== 32'd8 || busy !== 1'b0) begin errors++; $display("FAIL ovf_final: got count=%0d busy=%b want 8/0", words_written, busy); end
  endtask

  task automatic test_misaligned();
    step(1, 0, 32'h0, 32'h0, 0, 0);
    obs.delete();
    step(0, 1, 32'h102, 32'h55, 1, 0);
    idle(4, 1);
    checks++; if (misaligned !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL mis_flags: got mis=%b ovf=%b want 1/0", misaligned, overflow); end
    checks++; if (busy !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL mis_idle: got busy=%b we=%b want 0/0", busy, mem_write_en); end
    checks++; if (words_written !== 32'd0 || obs.size() != 0) begin errors++; $display("FAIL mis_no_write: got count=%0d obs=%0d want 0/0", words_written, obs.size()); end
  endtask

  task automatic test_core_reset();
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 1);
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL crst_req: got %b want 1", core_reset); end
    step(0, 1, 32'h300, 32'hA0, 0, 1);
    step(0, 1, 32'h304, 32'hA1, 0, 0);
    for (int c = 0; c < 30 && words_written < 2; c++) begin
      checks++;
      if (core_reset !== 1'b1) begin errors++; $display("FAIL crst_hold%0d: got %b want 1", c, core_reset); end
      step(0, 0, 32'h0, 32'h0, 1, 0);
    end
    checks++; if (words_written !== 32'd2 || busy !== 1'b0) begin errors++; $display("FAIL crst_done: got count=%0d busy=%b want 2/0", words_written, busy); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL crst_at_ack: got %b want 1", core_reset); end
    step(0, 0, 32'h0, 32'h0, 0, 0);
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL crst_release: got %b want 0", core_reset); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    step(1, 0, 32'h0, 32'h0, 0, 0);
    obs.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      exp_q.push_back({32'h400 + 32'(4 * i), d});
      step(0, 1, 32'h400 + 32'(4 * i), d, 0, 0);
    end
    checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL fpp_req: got %b want 1", mem_write_en); end
    d = $urandom;
    exp_q.push_back({32'h500, d});
    step(0, 1, 32'h500, d, 1, 0);
    checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fpp_accept: got ovf=%b busy=%b want 0/1", overflow, busy); end
    for (int c = 0; c < 40 && obs.size() < 9; c++) idle(1, 1);
    idle(4, 1);
    checks++; if (obs.size() != 9) begin errors++; $display("FAIL fpp_drain_count: got %0d want 9", obs.size()); end
    for (int i = 0; i < 9 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_order%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_final: got %b want 0", overflow); end
  endtask

  task automatic test_reset_during_req();
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(0, 1, 32'h600, 32'h11, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 1, 32'h601, 32'h22, 0, 0);
    step(0, 1, 32'h604, 32'h33, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (mem_write_en !== 1'b1 || misaligned !== 1'b1 || words_written !== 32'd1) begin
      errors++;
      $display("FAIL rdr_pre: got we=%b mis=%b count=%0d want 1/1/1", mem_write_en, misaligned, words_written);
    end
    step(1, 0, 32'h0, 32'h0, 0, 0);
    checks++; if (mem_write_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rdr_abandon: got we=%b busy=%b want 0/0", mem_write_en, busy); end
    checks++; if (words_written !== 32'd0 || misaligned !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rdr_clear: got count=%0d mis=%b ovf=%b want 0/0/0", words_written, misaligned, overflow); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rdr_core: got %b want 1", core_reset); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          we;
    bit          ack;
    bit          lrst;
    bit          rst;
    step(1, 0, 32'h0, 32'h0, 0, 0);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      we   = $urandom_range(0, 2) != 0;
      a    = $urandom;
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      ack  = $urandom_range(0, 2) == 0;
      lrst = $urandom_range(0, 15) == 0;
      rst  = $urandom_range(0, 299) == 0;
      step(rst, we, a, $urandom, ack, lrst);
      checks++; if (mem_write_en !== m_act) begin errors++; $display("FAIL rnd_we@%0d: got %b want %b", cyc, mem_write_en, m_act); end
      checks++; if (busy !== ((mq.size() != 0) || m_act)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, (mq.size() != 0) || m_act); end
      checks++; if (words_written !== m_cnt) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, words_written, m_cnt); end
      checks++; if (core_reset !== m_crst) begin errors++; $display("FAIL rnd_core@%0d: got %b want %b", cyc, core_reset, m_crst); end
      checks++; if (overflow !== m_ovf || misaligned !== m_mis) begin errors++; $display("FAIL rnd_flags@%0d: got ovf=%b mis=%b want %b/%b", cyc, overflow, misaligned, m_ovf, m_mis); end
      if (m_act) begin
        checks++;
        if ({mem_addr, mem_data} !== mq[0]) begin errors++; $display("FAIL rnd_req@%0d: got %h_%h want %h", cyc, mem_addr, mem_data, mq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_misaligned();
    test_core_reset();
    test_full_push_pop();
    test_reset_during_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
